// File: rtl/hdmi_cfg_sequencer.sv
// rtl/hdmi_cfg_sequencer.sv - walks the HDMI transmitter register table and writes it over a byte-level I2C master
module hdmi_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR  = 8'h72,
    parameter int          N_REGS    = 31,
    parameter int          PWRUP_CYC = 1_000_000,
    parameter int          MAX_RETRY = 3
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    output logic [$clog2(N_REGS)-1:0] tbl_addr,
    input  logic [15:0]               tbl_data,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [7:0]                cmd_data,
    output logic                      cmd_start,
    output logic                      cmd_stop,
    input  logic                      rsp_valid,
    input  logic                      rsp_ack,
    input  logic                      HDMI_TX_INT,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    output logic                      cfg_error
);
    localparam int AW = $clog2(N_REGS);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int CW = $clog2(PWRUP_CYC + 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_FETCH, S_LATCH, S_B0, S_B1, S_B2, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic          issue, issue_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [AW-1:0] addr_nxt;
    logic [RW-1:0] retries, retries_nxt;
    logic [7:0]    reg_r, reg_nxt;
    logic [7:0]    val_r, val_nxt;
    logic [1:0]    int_sync;
    logic          int_prev;
    logic          pend, pend_clr;
    logic          in_byte;
    logic          valid_nxt, start_nxt, stop_nxt;
    logic [7:0]    data_nxt;
    logic          busy_nxt, done_nxt, err_nxt;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= S_PWRUP;
            issue     <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            tbl_addr  <= '0;
            retries   <= '0;
            reg_r     <= '0;
            val_r     <= '0;
            int_sync  <= 2'b11;
            int_prev  <= 1'b1;
            pend      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            cmd_start <= 1'b0;
            cmd_stop  <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            issue     <= issue_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            tbl_addr  <= addr_nxt;
            retries   <= retries_nxt;
            reg_r     <= reg_nxt;
            val_r     <= val_nxt;
            int_sync  <= {int_sync[0], HDMI_TX_INT};
            int_prev  <= int_sync[1];
            // a new hot-plug edge wins over a same-cycle clear so it is never lost
            pend      <= (int_prev & ~int_sync[1]) | (pend & ~pend_clr);
            cmd_valid <= valid_nxt;
            cmd_data  <= data_nxt;
            cmd_start <= start_nxt;
            cmd_stop  <= stop_nxt;
            cfg_busy  <= busy_nxt;
            cfg_done  <= done_nxt;
            cfg_error <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        issue_nxt   = issue;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        addr_nxt    = tbl_addr;
        retries_nxt = retries;
        reg_nxt     = reg_r;
        val_nxt     = val_r;
        pend_clr    = 1'b0;

        case (state)
            S_PWRUP: begin
                if (cnt == CW'(PWRUP_CYC)) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = idx;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: begin
                reg_nxt   = tbl_data[15:8];
                val_nxt   = tbl_data[7:0];
                state_nxt = S_B0;
                issue_nxt = 1'b1;
            end
            S_B0, S_B1, S_B2: begin
                if (issue) begin
                    if (cmd_ready) issue_nxt = 1'b0;
                end else if (rsp_valid) begin
                    issue_nxt = 1'b1;
                    if (rsp_ack) begin
                        case (state)
                            S_B0:    state_nxt = S_B1;
                            S_B1:    state_nxt = S_B2;
                            default: begin
                                if (idx == AW'(N_REGS - 1)) begin
                                    state_nxt = S_DONE;
                                end else begin
                                    idx_nxt     = idx + 1'b1;
                                    addr_nxt    = idx + 1'b1;
                                    retries_nxt = '0;
                                    state_nxt   = S_FETCH;
                                end
                            end
                        endcase
                    end else if (retries < RW'(MAX_RETRY)) begin
                        // reg_r/val_r still hold the entry, so resend without refetching
                        retries_nxt = retries + 1'b1;
                        state_nxt   = S_B0;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (pend) begin
                    pend_clr    = 1'b1;
                    idx_nxt     = '0;
                    addr_nxt    = '0;
                    retries_nxt = '0;
                    state_nxt   = S_FETCH;
                end
            end
            default: state_nxt = S_PWRUP;
        endcase

        in_byte   = (state_nxt == S_B0) || (state_nxt == S_B1) || (state_nxt == S_B2);
        valid_nxt = in_byte && issue_nxt;
        start_nxt = (state_nxt == S_B0);
        stop_nxt  = (state_nxt == S_B2);
        case (state_nxt)
            S_B0:    data_nxt = DEV_ADDR;
            S_B1:    data_nxt = reg_nxt;
            S_B2:    data_nxt = val_nxt;
            default: data_nxt = 8'h00;
        endcase
        busy_nxt = (state_nxt != S_DONE) && (state_nxt != S_ERR);
        done_nxt = (state_nxt == S_DONE);
        err_nxt  = (state_nxt == S_ERR);
    end
endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// tb/tb_hdmi_cfg_sequencer.sv - directed self-checking bench for hdmi_cfg_sequencer
module tb_hdmi_cfg_sequencer;
    localparam int N_REGS    = 4;
    localparam int PWRUP_CYC = 16;
    localparam int MAX_RETRY = 2;
    localparam int AW        = $clog2(N_REGS);

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic [7:0]    cmd_data;
    logic          cmd_start;
    logic          cmd_stop;
    logic          rsp_valid = 1'b0;
    logic          rsp_ack = 1'b0;
    logic          HDMI_TX_INT = 1'b1;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_error;

    hdmi_cfg_sequencer #(
        .DEV_ADDR (8'h72),
        .N_REGS   (N_REGS),
        .PWRUP_CYC(PWRUP_CYC),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .rsp_valid  (rsp_valid),
        .rsp_ack    (rsp_ack),
        .HDMI_TX_INT(HDMI_TX_INT),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error)
    );

    always #5 iCLK = ~iCLK;

    logic [15:0] rom [N_REGS] = '{16'h4110, 16'h9803, 16'hD6C0, 16'hAF06};
    always @(posedge iCLK) tbl_data <= rom[tbl_addr];

    int cyc = 0;
    always @(posedge iCLK) cyc <= iRST ? 0 : cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];
    logic [63:0] nack_mask = '0;
    int         first_cv = -1;
    int         retry_imm = 0;
    int         mark;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // I2C master model: ready 2 cycles after valid, response 8 cycles after acceptance
    initial begin
        int ms;
        int cnt;
        ms = 0;
        cnt = 0;
        forever begin
            @(posedge iCLK);
            #1;
            if (iRST) begin
                ms = 0;
                cmd_ready = 1'b0;
                rsp_valid = 1'b0;
                rsp_ack = 1'b0;
                continue;
            end
            case (ms)
                0: if (cmd_valid) begin
                    if (first_cv < 0) first_cv = cyc;
                    cnt = 2;
                    ms = 1;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        cmd_ready = 1'b1;
                        log_q.push_back({cmd_start, cmd_stop, cmd_data});
                        ms = 2;
                    end
                end
                2: begin
                    cmd_ready = 1'b0;
                    cnt = 8;
                    ms = 3;
                end
                3: begin
                    cnt--;
                    if (cnt == 0) begin
                        rsp_valid = 1'b1;
                        rsp_ack = !nack_mask[log_q.size() - 1];
                        ms = 4;
                    end
                end
                default: begin
                    rsp_valid = 1'b0;
                    if (!rsp_ack && cmd_valid) retry_imm++;
                    ms = 0;
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int budget);
        for (int i = 0; i < budget && cfg_busy !== lvl; i++) tick(1);
        check(tag, cfg_busy, lvl);
    endtask

    task automatic assert_reset();
        #2 iRST = 1'b1;
        tick(3);
    endtask

    task automatic release_reset();
        @(negedge iCLK);
        log_q.delete();
        exp_q.delete();
        first_cv = -1;
        nack_mask = '0;
        retry_imm = 0;
        iRST = 1'b0;
        tick(1);
    endtask

    task automatic push_cmd(input logic s, input logic p, input logic [7:0] d);
        exp_q.push_back({s, p, d});
    endtask

    task automatic push_entry(input int i);
        logic [15:0] e;
        e = rom[i];
        push_cmd(1'b1, 1'b0, 8'h72);
        push_cmd(1'b0, 1'b0, e[15:8]);
        push_cmd(1'b0, 1'b1, e[7:0]);
    endtask

    task automatic push_pass();
        for (int i = 0; i < N_REGS; i++) push_entry(i);
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), log_q[i], exp_q[i]);
    endtask

    task automatic pulse_int();
        HDMI_TX_INT = 1'b0;
        tick(4);
        HDMI_TX_INT = 1'b1;
    endtask

    initial begin
        // reset state
        assert_reset();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_start", cmd_start, 0);
        check("rst_cmd_stop", cmd_stop, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_error", cfg_error, 0);
        release_reset();
        check("busy_first_edge", cfg_busy, 1);

        // clean pass
        push_pass();
        wait_busy("pass1_idle", 1'b0, 1000);
        check("pass1_first_cv", first_cv, 19);
        cmp_log("pass1");
        check("pass1_done", cfg_done, 1);
        check("pass1_error", cfg_error, 0);

        // hot-plug replay from DONE, no power-up wait
        log_q.delete();
        exp_q.delete();
        first_cv = -1;
        mark = cyc;
        pulse_int();
        wait_busy("replay_start", 1'b1, 50);
        push_pass();
        wait_busy("replay_idle", 1'b0, 1000);
        check("replay_latency", first_cv - mark, 6);
        cmp_log("replay");
        check("replay_done", cfg_done, 1);

        // single NACK on B1 of entry 1
        assert_reset();
        release_reset();
        nack_mask[4] = 1'b1;
        push_entry(0);
        push_cmd(1'b1, 1'b0, 8'h72);
        push_cmd(1'b0, 1'b0, 8'h98);
        push_entry(1);
        push_entry(2);
        push_entry(3);
        wait_busy("nack1_idle", 1'b0, 1000);
        cmp_log("nack1");
        check("nack1_no_refetch", retry_imm, 1);
        check("nack1_done", cfg_done, 1);
        check("nack1_error", cfg_error, 0);

        // retries exhausted on entry 2
        assert_reset();
        release_reset();
        nack_mask[8:6] = 3'b111;
        push_entry(0);
        push_entry(1);
        repeat (3) push_cmd(1'b1, 1'b0, 8'h72);
        wait_busy("err_idle", 1'b0, 1000);
        cmp_log("err");
        check("err_error", cfg_error, 1);
        check("err_done", cfg_done, 0);
        check("err_retry_imm", retry_imm, 2);
        tick(50);
        check("err_quiet", log_q.size(), 9);
        check("err_hold", cfg_error, 1);

        // hot-plug replay from ERR
        log_q.delete();
        exp_q.delete();
        nack_mask = '0;
        pulse_int();
        wait_busy("err_replay_start", 1'b1, 50);
        push_pass();
        wait_busy("err_replay_idle", 1'b0, 1000);
        cmp_log("err_replay");
        check("err_replay_done", cfg_done, 1);
        check("err_replay_error", cfg_error, 0);

        // two INT pulses mid-pass give exactly one replay
        assert_reset();
        release_reset();
        for (int i = 0; i < 1000 && log_q.size() < 4; i++) tick(1);
        check("mid_reach", log_q.size() >= 4, 1);
        pulse_int();
        tick(20);
        pulse_int();
        check("mid_still_busy", cfg_busy, 1);
        wait_busy("mid_first_done", 1'b0, 1000);
        wait_busy("mid_replay_start", 1'b1, 20);
        wait_busy("mid_replay_done", 1'b0, 1000);
        tick(60);
        push_pass();
        push_pass();
        cmp_log("mid");
        check("mid_busy_final", cfg_busy, 0);
        check("mid_done_final", cfg_done, 1);

        // asynchronous reset while B1 is being offered
        assert_reset();
        release_reset();
        for (int i = 0; i < 200 && !(log_q.size() == 1 && cmd_valid && cmd_data == 8'h41); i++) tick(1);
        check("ar_in_b1", cmd_valid, 1);
        #2 iRST = 1'b1;
        #1;
        check("ar_valid_drop", cmd_valid, 0);
        check("ar_busy_drop", cfg_busy, 0);
        tick(2);
        release_reset();
        push_pass();
        wait_busy("ar_idle", 1'b0, 1000);
        check("ar_first_cv", first_cv, 19);
        cmp_log("ar");
        check("ar_done", cfg_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_cfg_sequencer.md
# hdmi_cfg_sequencer

Configures the HDMI transmitter over I2C from a register table. After power-up it walks a table of {register, value} pairs in order and writes each pair to the transmitter through a byte-level I2C master, using a valid/ready command handshake. NACKed writes are retried. The whole table is replayed when the transmitter asserts its interrupt (hot-plug). It sits between the board clock domain, the register ROM and the I2C master that drives HDMI_I2C_SCL/SDA.

## Interface
- DEV_ADDR, 8'h72: 8-bit I2C write address of the transmitter (R/W bit = 0).
- N_REGS, 31: number of table entries; table indices run 0..N_REGS-1.
- PWRUP_CYC, 1_000_000: iCLK cycles to wait after reset before the first write.
- MAX_RETRY, 3: retries per table entry after the first attempt.

Ports:
- iCLK  in  1  system clock (50 MHz); the only clock.
- iRST  in  1  reset, asynchronous and active-high.
- tbl_addr  out  $clog2(N_REGS)  table index, registered.
- tbl_data  in  16  {reg[15:8], val[7:0]}; synchronous ROM, valid 1 cycle after tbl_addr changes.
- cmd_valid  out  1  byte command valid.
- cmd_ready  in  1  master accepts the command.
- cmd_data  out  8  byte to transmit.
- cmd_start  out  1  generate START before this byte.
- cmd_stop  out  1  generate STOP after this byte.
- rsp_valid  in  1  one-cycle pulse: byte finished.
- rsp_ack  in  1  slave ACKed; qualified by rsp_valid.
- HDMI_TX_INT  in  1  transmitter interrupt, active-low, asynchronous.
- cfg_busy  out  1  table pass in progress, or power-up wait.
- cfg_done  out  1  last pass completed with every entry ACKed.
- cfg_error  out  1  last pass aborted because retries were exhausted.

## Operation
- HDMI_TX_INT passes through a 2-FF synchronizer (reset to 1). A falling edge of the synchronized signal sets `pend`.
- States and transitions:
  - PWRUP: counts PWRUP_CYC cycles, then FETCH.
  - FETCH: drives tbl_addr = idx, then goes to LATCH.
  - LATCH: captures tbl_data into reg_r/val_r, then goes to B0.
  - B0: sends cmd_data = DEV_ADDR with start = 1, stop = 0.
  - B1: sends reg_r with start = 0, stop = 0.
  - B2: sends val_r with start = 0, stop = 1.
  - DONE / ERR: idle until restarted.
- Each Bn state has two phases:
  - Issue: hold cmd_valid = 1 with stable data/start/stop until cmd_ready = 1 in the same cycle; the transfer happens on that edge.
  - Wait: cmd_valid = 0 until rsp_valid.
    - rsp_ack = 1: advance to the next byte.
    - rsp_ack = 0: the master issues STOP on its own, with no further commands.
- Entry completion and advance:
  - After B2 is ACKed, the entry is complete.
  - If idx == N_REGS-1, go to DONE; otherwise idx++, retries = 0, go to FETCH.
- NACK on any byte:
  - If retries < MAX_RETRY: retries++ and return to B0 with the same entry. No refetch, since reg_r/val_r are held.
  - Otherwise go to ERR.
- Restart:
  - In DONE or ERR with `pend` = 1: clear `pend`, set idx = 0, retries = 0, go to FETCH. No power-up wait.
  - An edge arriving mid-pass only sets `pend`. The current pass finishes, and the replay starts from DONE/ERR on the next cycle.
- Outputs by state:
  - cfg_busy = 1 in all states except DONE and ERR.
  - cfg_done = 1 only in DONE.
  - cfg_error = 1 only in ERR.
  - cfg_done and cfg_error are never both 1.
- Width rules:
  - idx and tbl_addr are $clog2(N_REGS) bits, with no wrap past N_REGS-1.
  - retries is $clog2(MAX_RETRY+1) bits and saturates at MAX_RETRY.
  - The power-up counter is $clog2(PWRUP_CYC+1) bits.

## Timing
- Reset values:
  - State PWRUP; power-up counter 0.
  - idx = 0, tbl_addr = 0, retries = 0, pend = 0.
  - cmd_valid = cmd_start = cmd_stop = 0; cmd_data = 0.
  - cfg_busy = 0, cfg_done = 0, cfg_error = 0.
  - cfg_busy becomes 1 on the first edge after iRST deasserts.
- Reset mid-transaction: all state clears immediately. The I2C master is reset by the same iRST; no STOP is owed.
- cmd_valid is asserted on the edge entering Bn. It is not withdrawn before acceptance.
- cmd_ready is ignored while cmd_valid = 0.
- rsp_valid arriving in the same cycle as acceptance (zero-latency master) is not legal; the bench never drives it.
- The first cmd_valid appears PWRUP_CYC+3 cycles after reset deassertion: PWRUP count, then FETCH, then LATCH.
- Per-entry sequencer overhead is 2 cycles (FETCH, LATCH) plus 1 cycle per byte response handling. All other time is set by the master.
- Latency from an HDMI_TX_INT falling edge to `pend`: 3 cycles.

## Test plan
Common bench setup: N_REGS=4, PWRUP_CYC=16, MAX_RETRY=2. The bench's master model asserts cmd_ready 2 cycles after cmd_valid, then rsp_valid 8 cycles later.
- Clean pass → 12 commands in order 72/reg0/val0 … 72/reg3/val3, with start only on the 72 bytes and stop only on val bytes. First cmd_valid at cycle 19. cfg_done = 1, cfg_busy = 0 after the last rsp.
- NACK on B1 of entry 1, once → entry 1 is resent from B0 with identical bytes; tbl_addr is not refetched; the pass ends in DONE.
- NACK on entry 2 for 3 consecutive attempts → ERR, cfg_error = 1, cfg_done = 0; no further commands are issued.
- HDMI_TX_INT pulses low for 4 cycles in DONE → full 12-byte replay from idx 0 with no power-up wait; ends in DONE.
- INT pulse during entry 1 of the first pass → first pass completes, then exactly one replay; two pulses mid-pass still give a single replay.
- iRST asserted while cmd_valid = 1 in B1 → cmd_valid = 0 asynchronously; after release, a fresh 16-cycle power-up and a pass from idx 0.
